// File: rtl/period_meas_ctrl.sv
// Averaging sip-period measurement controller for the frequency multiplier.
// Optional LOAD wait timeout enabled by defining TIMEOUT_EN.
module period_meas_ctrl #(
  parameter int CNT_W    = 8,
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sip,
  input  logic             adjust,
  output logic             valid,
  output logic             busy,
  output logic [CNT_W-1:0] period,
  output logic             ovf,
  output logic             timeout
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_LOAD,
    S_COUNT
  } state_e;

  state_e             state_q;
  logic               sip_q;
  logic [ACC_W-1:0]   acc_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   period_q;
  logic               ovf_q;
  logic               done_q;
  logic               busy_q;

  logic               rise;
  logic [ACC_W:0]     acc_d;
  logic               sat;
  logic [CNT_W-1:0]   period_d;

  assign rise     = sip & ~sip_q;
  assign acc_d    = {1'b0, acc_q} + 1'b1;
  assign sat      = acc_d[ACC_W];
  // divide by the number of averaged periods, truncating
  assign period_d = acc_d[ACC_W-1:AVG_LOG2];

`ifdef TIMEOUT_EN
  logic [CNT_W-1:0]   wait_q;
  logic               tmo_q;
  logic               wait_end;

  assign wait_end = &wait_q;
  assign timeout  = tmo_q;
`else
  assign timeout  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      sip_q    <= 1'b0;
      acc_q    <= '0;
      idx_q    <= '0;
      period_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef TIMEOUT_EN
      wait_q   <= '0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      sip_q <= sip;
      case (state_q)
        S_IDLE: begin
          if (adjust) begin
            state_q <= S_START;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          ovf_q <= 1'b0;
          acc_q <= '0;
          idx_q <= '0;
`ifdef TIMEOUT_EN
          tmo_q  <= 1'b0;
          wait_q <= '0;
`endif
          if (!adjust) begin
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          acc_q <= '0;
          idx_q <= '0;
          if (adjust) begin
            state_q <= S_START;
          end else if (rise) begin
            state_q <= S_COUNT;
`ifdef TIMEOUT_EN
          end else if (wait_end) begin
            state_q <= S_IDLE;
            tmo_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            wait_q  <= wait_q + 1'b1;
`endif
          end
        end
        S_COUNT: begin
          if (adjust) begin
            state_q <= S_START;
          end else if (sat) begin
            state_q  <= S_IDLE;
            period_q <= '1;
            ovf_q    <= 1'b1;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
          end else begin
            acc_q <= acc_d[ACC_W-1:0];
            if (rise) begin
              idx_q <= idx_q + 1'b1;
              if (idx_q == IDX_LAST) begin
                state_q  <= S_IDLE;
                period_q <= period_d;
                done_q   <= 1'b1;
                busy_q   <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign valid  = done_q;
  assign busy   = busy_q;
  assign period = period_q;
  assign ovf    = ovf_q;

endmodule
